count_checker: RTL

COUNT_CHECKER -- requirements
Module: count_checker

---
 rtl/count_checker.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/count_checker.sv
// Checks that an external saturating up-counter ramps 0..MAX_VAL without skips
// and then holds at MAX_VAL; reports a pass/fail verdict plus first-violation info.
module count_checker #(
  parameter logic [7:0]  MAX_VAL     = 8'hFF,
  parameter int          HOLD_CYCLES = 16,
  parameter logic [15:0] TIMEOUT     = 16'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  count,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        fail,
  output logic [7:0]  err_count,
  output logic [7:0]  first_err,
  output logic [1:0]  err_code,
  output logic [15:0] cycles
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_ZERO,
    S_TRACK,
    S_HOLD,
    S_DONE
  } state_t;

  localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);
  localparam logic [15:0] TO_LAST   = TIMEOUT - 16'd1;

  localparam logic [1:0] CODE_NONE    = 2'd0;
  localparam logic [1:0] CODE_TIMEOUT = 2'd1;
  localparam logic [1:0] CODE_SEQ     = 2'd2;
  localparam logic [1:0] CODE_HOLD    = 2'd3;

  state_t      r_state, w_state_nxt;
  logic [7:0]  r_prev, w_prev_nxt;
  logic [15:0] r_hold, w_hold_nxt;
  logic [15:0] r_cycles, w_cycles_nxt;
  logic [7:0]  r_err_count, w_err_count_nxt;
  logic [7:0]  r_first_err, w_first_err_nxt;
  logic [1:0]  r_err_code, w_err_code_nxt;
  logic        r_pass, w_pass_nxt;
  logic        r_fail, w_fail_nxt;

  logic        w_busy;
  logic        w_timeout;
  logic        w_seq_ok;
  logic        w_seq_err;
  logic        w_hold_err;
  logic [1:0]  w_nviol;
  logic [8:0]  w_err_sum;
  logic [7:0]  w_err_sat;

  assign w_busy     = (r_state == S_WAIT_ZERO) || (r_state == S_TRACK) || (r_state == S_HOLD);
  assign w_timeout  = w_busy && (r_cycles == TO_LAST);
  // 9-bit compare so prev=255 does not wrap around to accept count=0
  assign w_seq_ok   = (count == r_prev) || ({1'b0, count} == ({1'b0, r_prev} + 9'd1));
  assign w_seq_err  = (r_state == S_TRACK) && !w_seq_ok;
  assign w_hold_err = (r_state == S_HOLD) && (count != MAX_VAL);
  assign w_nviol    = 2'(w_timeout) + 2'(w_seq_err) + 2'(w_hold_err);
  assign w_err_sum  = {1'b0, r_err_count} + {7'd0, w_nviol};
  assign w_err_sat  = w_err_sum[8] ? 8'hFF : w_err_sum[7:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_prev_nxt      = r_prev;
    w_hold_nxt      = r_hold;
    w_cycles_nxt    = r_cycles;
    w_err_count_nxt = r_err_count;
    w_first_err_nxt = r_first_err;
    w_err_code_nxt  = r_err_code;
    w_pass_nxt      = r_pass;
    w_fail_nxt      = r_fail;

    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state_nxt     = S_WAIT_ZERO;
          w_prev_nxt      = 8'd0;
          w_hold_nxt      = 16'd0;
          w_cycles_nxt    = 16'd0;
          w_err_count_nxt = 8'd0;
          w_first_err_nxt = 8'd0;
          w_err_code_nxt  = CODE_NONE;
          w_pass_nxt      = 1'b0;
          w_fail_nxt      = 1'b0;
        end
      end
      S_WAIT_ZERO: begin
        if (count == 8'd0) begin
          w_state_nxt = S_TRACK;
          w_prev_nxt  = 8'd0;
        end
      end
      S_TRACK: begin
        // legal or not, resynchronise to the observed value
        w_prev_nxt = count;
        if (count == MAX_VAL) begin
          w_state_nxt = S_HOLD;
          w_hold_nxt  = 16'd0;
        end
      end
      S_HOLD: begin
        if (r_hold == HOLD_LAST) w_state_nxt = S_DONE;
        else                     w_hold_nxt  = r_hold + 16'd1;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (w_busy) begin
      if (w_timeout) w_state_nxt  = S_DONE;
      else           w_cycles_nxt = r_cycles + 16'd1;

      if (w_nviol != 2'd0) begin
        w_err_count_nxt = w_err_sat;
        // err_count only ever climbs within a run, so zero marks "no violation yet"
        if (r_err_count == 8'd0) begin
          w_first_err_nxt = count;
          if (w_timeout)      w_err_code_nxt = CODE_TIMEOUT;
          else if (w_seq_err) w_err_code_nxt = CODE_SEQ;
          else                w_err_code_nxt = CODE_HOLD;
        end
      end

      if (w_state_nxt == S_DONE) begin
        w_pass_nxt = (w_err_count_nxt == 8'd0);
        w_fail_nxt = (w_err_count_nxt != 8'd0);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev      <= 8'd0;
      r_hold      <= 16'd0;
      r_cycles    <= 16'd0;
      r_err_count <= 8'd0;
      r_first_err <= 8'd0;
      r_err_code  <= CODE_NONE;
      r_pass      <= 1'b0;
      r_fail      <= 1'b0;
    end else begin
      r_prev      <= w_prev_nxt;
      r_hold      <= w_hold_nxt;
      r_cycles    <= w_cycles_nxt;
      r_err_count <= w_err_count_nxt;
      r_first_err <= w_first_err_nxt;
      r_err_code  <= w_err_code_nxt;
      r_pass      <= w_pass_nxt;
      r_fail      <= w_fail_nxt;
    end
  end

  assign busy      = w_busy;
  assign done      = (r_state == S_DONE);
  assign pass      = r_pass;
  assign fail      = r_fail;
  assign err_count = r_err_count;
  assign first_err = r_first_err;
  assign err_code  = r_err_code;
  assign cycles    = r_cycles;

endmodule
